mem_stage_sram_ctrl: RTL and testbench

Memory-stage controller that sits directly downstream of the EX/MEM pipeline register. It consumes the registered ALU result (address), Rm value (store data) and the mem_read/mem_write controls. It performs each 32-bit load or store as two 16-bit accesses to an external asynchronous SRAM. While an access is in flight it holds `ready` low, and the hazard/freeze logic uses that signal to stall all pipeline registers.

---
 rtl/mem_stage_sram_ctrl_pkg.sv | 17 +
 rtl/mem_stage_sram_ctrl.sv | 126 ++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_sram_ctrl_pkg.sv
// rtl/mem_stage_sram_ctrl_pkg.sv - shared widths and FSM state type for the memory-stage SRAM controller
package mem_stage_sram_ctrl_pkg;

  localparam int WORD_WIDTH    = 32;
  localparam int SRAM_ADDR_W   = 18;
  localparam int SRAM_DATA_W   = 16;
  localparam int DATA_MEM_BASE = 1024;

  typedef enum logic [2:0] {
    IDLE,
    ACC_LO,
    ACC_HI,
    WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/mem_stage_sram_ctrl.sv
// rtl/mem_stage_sram_ctrl.sv - splits each 32-bit load/store into two 16-bit async SRAM accesses
// and holds ready low so the pipeline freezes until the access has settled.
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int WORD_WIDTH    = mem_stage_sram_ctrl_pkg::WORD_WIDTH,
  parameter int SRAM_ADDR_W   = mem_stage_sram_ctrl_pkg::SRAM_ADDR_W,
  parameter int SRAM_DATA_W   = mem_stage_sram_ctrl_pkg::SRAM_DATA_W,
  parameter int DATA_MEM_BASE = mem_stage_sram_ctrl_pkg::DATA_MEM_BASE,
  parameter int WAIT_CYCLES   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_read_in,
  input  logic                   mem_write_in,
  input  logic [WORD_WIDTH-1:0]  address_in,
  input  logic [WORD_WIDTH-1:0]  write_data_in,
  output logic [WORD_WIDTH-1:0]  read_data_out,
  output logic                   ready,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]      CNT_INIT = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [WORD_WIDTH-1:0] BASE     = WORD_WIDTH'(DATA_MEM_BASE);

  state_e                 state_q;
  logic [CNT_W-1:0]       wait_cnt_q;
  logic [WORD_WIDTH-1:0]  addr_q;
  logic [WORD_WIDTH-1:0]  data_q;
  logic [WORD_WIDTH-1:0]  rdata_q;
  logic                   is_write_q;
  logic                   we_n_q;
  logic                   dq_oe_q;
  logic [SRAM_DATA_W-1:0] dq_out_q;
  logic [SRAM_ADDR_W-1:0] sram_addr_q;

  logic [WORD_WIDTH-1:0]  eff_d;
  logic                   req;
  logic                   unused_addr_bits;

  assign eff_d = address_in - BASE;
  assign req   = mem_read_in | mem_write_in;

  // Only the half-word index bits reach the SRAM; the rest are deliberately dropped.
  assign unused_addr_bits = ^{addr_q[WORD_WIDTH-1:SRAM_ADDR_W+1], addr_q[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      rdata_q     <= '0;
      is_write_q  <= 1'b0;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
      sram_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            state_q     <= ACC_LO;
            addr_q      <= eff_d;
            data_q      <= write_data_in;
            is_write_q  <= mem_write_in;
            sram_addr_q <= {eff_d[SRAM_ADDR_W:2], 1'b0};
            we_n_q      <= ~mem_write_in;
            dq_oe_q     <= mem_write_in;
            dq_out_q    <= write_data_in[SRAM_DATA_W-1:0];
          end
        end
        ACC_LO: begin
          if (!is_write_q) begin
            rdata_q[SRAM_DATA_W-1:0] <= SRAM_DQ;
          end
          sram_addr_q <= {addr_q[SRAM_ADDR_W:2], 1'b1};
          dq_out_q    <= data_q[WORD_WIDTH-1:SRAM_DATA_W];
          state_q     <= ACC_HI;
        end
        ACC_HI: begin
          if (!is_write_q) begin
            rdata_q[WORD_WIDTH-1:SRAM_DATA_W] <= SRAM_DQ;
          end
          we_n_q     <= 1'b1;
          dq_oe_q    <= 1'b0;
          wait_cnt_q <= CNT_INIT;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt_q == '0) begin
            state_q <= DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end
        DONE: begin
          sram_addr_q <= '0;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready = ((state_q == IDLE) && !req) || (state_q == DONE);

  assign SRAM_DQ       = dq_oe_q ? dq_out_q : {SRAM_DATA_W{1'bz}};
  assign SRAM_ADDR     = sram_addr_q;
  assign SRAM_WE_N     = we_n_q;
  assign SRAM_CE_N     = 1'b0;
  assign SRAM_OE_N     = 1'b0;
  assign SRAM_UB_N     = 1'b0;
  assign SRAM_LB_N     = 1'b0;
  assign read_data_out = rdata_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb/tb_mem_stage_sram_ctrl.sv - scoreboard bench for mem_stage_sram_ctrl with a behavioural async SRAM
module sram_model (
  input  logic        clk,
  input  logic [17:0] addr,
  inout  wire  [15:0] dq,
  input  logic        we_n,
  input  logic        oe_n,
  input  logic        ce_n
);
  logic [15:0] mem [0:262143];

  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
  end

  assign dq = (!ce_n && !oe_n && we_n) ? mem[addr] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ce_n && !we_n) mem[addr] <= dq;
  end
endmodule

module tb_mem_stage_sram_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [31:0] address_in;
  logic [31:0] write_data_in;
  logic [31:0] read_data_out;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n;

  always #5 clk = ~clk;

  mem_stage_sram_ctrl u_dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read_in  (mem_read_in),
    .mem_write_in (mem_write_in),
    .address_in   (address_in),
    .write_data_in(write_data_in),
    .read_data_out(read_data_out),
    .ready        (ready),
    .SRAM_DQ      (sram_dq),
    .SRAM_ADDR    (sram_addr),
    .SRAM_WE_N    (sram_we_n),
    .SRAM_CE_N    (sram_ce_n),
    .SRAM_OE_N    (sram_oe_n),
    .SRAM_UB_N    (sram_ub_n),
    .SRAM_LB_N    (sram_lb_n)
  );

  sram_model u_sram (
    .clk (clk),
    .addr(sram_addr),
    .dq  (sram_dq),
    .we_n(sram_we_n),
    .oe_n(sram_oe_n),
    .ce_n(sram_ce_n)
  );

  typedef struct {
    bit          is_load;
    logic [31:0] data;
    bit          we_low;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: a transaction completes on the first ready-high cycle after a low stretch.
  initial begin
    int   low_cnt;
    bit   we_seen;
    exp_t e;
    low_cnt = 0;
    we_seen = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        low_cnt = 0;
        we_seen = 0;
      end else if (!ready) begin
        low_cnt++;
        if (sram_we_n === 1'b0) we_seen = 1;
      end else if (low_cnt > 0) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: got completion want none");
        end else begin
          e = sb_q.pop_front();
          check("freeze_len", low_cnt, 32'd6);
          check("we_activity", {31'd0, we_seen}, {31'd0, e.we_low});
          if (e.is_load) check("load_data", read_data_out, e.data);
        end
        low_cnt = 0;
        we_seen = 0;
      end
    end
  end

  // Starts an op at cycle 0 (just after a rising edge) and returns at the negedge of its DONE cycle.
  task automatic run_op(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input int drop_at, input logic [31:0] exp_rd);
    exp_t e;
    int   cyc;
    bit   done;
    e.is_load = !wr;
    e.data    = exp_rd;
    e.we_low  = wr;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    mem_write_in  = wr;
    mem_read_in   = !wr;
    address_in    = addr;
    write_data_in = data;
    cyc  = 0;
    done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (cyc == 0) check("start_ready_low", {31'd0, ready}, 32'd0);
      if (cyc > 0 && ready) begin
        done = 1;
      end else begin
        @(posedge clk);
        #1;
        cyc++;
        if (cyc == drop_at) begin
          mem_write_in  = 1'b0;
          mem_read_in   = 1'b0;
          address_in    = 32'hFFFF_0000;
          write_data_in = 32'hA5A5_A5A5;
        end
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL op_timeout: got no completion want DONE within 40 cycles");
    end
  endtask

  initial begin
    rst           = 1'b1;
    mem_read_in   = 1'b0;
    mem_write_in  = 1'b0;
    address_in    = 32'd0;
    write_data_in = 32'd0;
    repeat (2) @(negedge clk);
    u_sram.mem[8] = 16'hF00D;
    u_sram.mem[9] = 16'hCAFE;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_rdata", read_data_out, 32'd0);
    check("rst_addr", {14'd0, sram_addr}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_op(1'b0, 32'd1040, 32'd0, -1, 32'hCAFE_F00D);

    // Store interrupted by reset while waiting for the SRAM to settle.
    @(posedge clk);
    #1;
    mem_write_in  = 1'b1;
    mem_read_in   = 1'b0;
    address_in    = 32'd1028;
    write_data_in = 32'h1111_2222;
    repeat (4) @(posedge clk);
    #1;
    rst          = 1'b1;
    mem_write_in = 1'b0;
    @(negedge clk);
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("midrst_rdata", read_data_out, 32'd0);
    check("midrst_addr", {14'd0, sram_addr}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);

    run_op(1'b1, 32'd1028, 32'hDEAD_BEEF, -1, 32'd0);
    check("sram2", {16'd0, u_sram.mem[2]}, 32'h0000_BEEF);
    check("sram3", {16'd0, u_sram.mem[3]}, 32'h0000_DEAD);
    run_op(1'b0, 32'd1028, 32'd0, -1, 32'hDEAD_BEEF);

    run_op(1'b1, 32'd1032, 32'h1234_5678, -1, 32'd0);
    run_op(1'b0, 32'd1032, 32'd0, -1, 32'h1234_5678);
    check("sram4", {16'd0, u_sram.mem[4]}, 32'h0000_5678);
    check("sram5", {16'd0, u_sram.mem[5]}, 32'h0000_1234);

    run_op(1'b0, 32'd1028, 32'd0, 2, 32'hDEAD_BEEF);

    u_sram.mem[0] = 16'h0000;
    @(posedge clk);
    #1;
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_ready", {31'd0, ready}, 32'd1);
      check("idle_addr", {14'd0, sram_addr}, 32'd0);
      check("idle_dq", {16'd0, sram_dq}, 32'd0);
      check("idle_rdata", read_data_out, 32'hDEAD_BEEF);
    end
    check("sb_drained", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
